gemm_result_writer: RTL

- Consumer end of the GeMM controller's result interface.
- Captures each finished Mu x Nu C block when result_valid pulses, together with its M/N block indices.
- Buffers up to two blocks, then serialises each block row by row onto the output SRAM write port, with SRAM back-pressure.
- Counts written blocks and flags completion once all M_size*N_size blocks are stored.

---
 rtl/gemm_writer_pkg.sv | 25 ++
 rtl/gemm_result_writer_if.sv | 33 +++
 rtl/result_block_fifo.sv | 68 ++++++
 rtl/gemm_result_writer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/gemm_writer_pkg.sv
// Shared types for the GeMM result writer.
// Holds the writer FSM state enum, the default geometry of one C block and
// the packed entry that travels through the block FIFO.
package gemm_writer_pkg;

    localparam int unsigned WriterAddrWidth  = 16;
    localparam int unsigned WriterDataWidth  = 32;
    localparam int unsigned WriterMu         = 4;
    localparam int unsigned WriterNu         = 4;
    localparam int unsigned WriterRowWidth   = WriterNu * WriterDataWidth;
    localparam int unsigned WriterBlockWidth = WriterMu * WriterRowWidth;

    typedef enum logic [0:0] {
        WrIdle = 1'b0,
        WrRow  = 1'b1
    } writer_state_t;

    // One buffered C block together with the block indices it belongs to.
    typedef struct packed {
        logic [WriterAddrWidth-1:0]  m_idx;
        logic [WriterAddrWidth-1:0]  n_idx;
        logic [WriterBlockWidth-1:0] data;
    } writer_entry_t;

endpackage

// File: rtl/gemm_result_writer_if.sv
// Output SRAM write port of the GeMM result writer.
//   sram_wr_en    : write request, held until accepted
//   sram_wr_addr  : word address
//   sram_wr_data  : one C block row
//   sram_wr_ready : SRAM accepts the request in this cycle
// master = writer side, slave = SRAM side.
interface gemm_result_writer_if
    import gemm_writer_pkg::*;
#(
    parameter int unsigned AddrWidth = WriterAddrWidth,
    parameter int unsigned WordWidth = WriterRowWidth
);

    logic                 sram_wr_en;
    logic [AddrWidth-1:0] sram_wr_addr;
    logic [WordWidth-1:0] sram_wr_data;
    logic                 sram_wr_ready;

    modport master (
        output sram_wr_en,
        output sram_wr_addr,
        output sram_wr_data,
        input  sram_wr_ready
    );

    modport slave (
        input  sram_wr_en,
        input  sram_wr_addr,
        input  sram_wr_data,
        output sram_wr_ready
    );

endinterface

// File: rtl/result_block_fifo.sv
// Small FIFO of whole C blocks between the result interface and the writer.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : store push_data_i (caller guarantees room or a same-cycle pop)
//   pop_i         : drop the head entry (caller guarantees non-empty)
//   head_o        : oldest stored entry
//   full_o/empty_o: occupancy flags
// A push and a pop in the same cycle on a full FIFO is legal: the head slot
// is released at the same edge the new entry is written to the free slot.
module result_block_fifo
    import gemm_writer_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  writer_entry_t push_data_i,
    input  logic          pop_i,
    output writer_entry_t head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    writer_entry_t   mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Block storage carries no reset; the occupancy count decides validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({push_i, pop_i})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);

endmodule

// File: rtl/gemm_result_writer.sv
// Consumer end of the GeMM controller's result interface.
// Captures each finished Mu x Nu C block on result_valid_i, buffers up to two
// blocks and writes them row by row to the output SRAM, one block row per word.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : new job, clears counters when not busy
//   M_size_i, N_size_i  : job size in blocks
//   result_valid_i      : one-cycle block strobe with M/N indices and data
//   sram_if             : SRAM write port (master side)
//   busy_o              : blocks buffered or a write in flight
//   blocks_written_o    : blocks stored since the last start
//   all_written_o       : whole job stored
//   overflow_o          : sticky, a block arrived with no room and was dropped
module gemm_result_writer
    import gemm_writer_pkg::*;
#(
    parameter int unsigned AddrWidth = WriterAddrWidth,
    parameter int unsigned DataWidth = WriterDataWidth,
    parameter int unsigned Mu        = WriterMu,
    parameter int unsigned Nu        = WriterNu,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [AddrWidth-1:0]      M_size_i,
    input  logic [AddrWidth-1:0]      N_size_i,
    input  logic                      result_valid_i,
    input  logic [AddrWidth-1:0]      M_count_write_i,
    input  logic [AddrWidth-1:0]      N_count_write_i,
    input  logic [Mu*Nu*DataWidth-1:0] result_data_i,
    gemm_result_writer_if.master      sram_if,
    output logic                      busy_o,
    output logic [AddrWidth-1:0]      blocks_written_o,
    output logic                      all_written_o,
    output logic                      overflow_o
);

    localparam int unsigned RowWidth = Nu * DataWidth;
    localparam int unsigned RowIdxW  = (Mu > 1) ? $clog2(Mu) : 1;

    writer_state_t        state;
    logic [RowIdxW-1:0]   row;
    writer_entry_t        push_entry;
    writer_entry_t        head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 row_accept;
    logic                 last_row;
    logic                 block_done;
    logic                 push_ok;
    logic                 start_ok;
    logic                 wr_active;
    logic [AddrWidth-1:0] row_base;
    logic [AddrWidth-1:0] job_blocks;

    assign push_entry = '{m_idx: M_count_write_i, n_idx: N_count_write_i, data: result_data_i};

    assign wr_active  = (state == WrRow);
    assign row_accept = wr_active && sram_if.sram_wr_ready;
    assign last_row   = (row == RowIdxW'(Mu - 1));
    assign block_done = row_accept && last_row;
    // A full FIFO still takes a block when its head leaves at the same edge.
    assign push_ok    = result_valid_i && (!fifo_full || block_done);
    assign busy_o     = !fifo_empty || wr_active;
    assign start_ok   = start_i && !busy_o;

    result_block_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_ok),
        .push_data_i (push_entry),
        .pop_i       (block_done),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Writer FSM. An arriving block into an empty FIFO starts writing right
    // at the capture edge, so row 0 appears the cycle after the strobe. After
    // the last row it continues straight into the next queued block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= WrIdle;
            row   <= '0;
        end else begin
            unique case (state)
                WrIdle: begin
                    if (!fifo_empty || push_ok) begin
                        state <= WrRow;
                        row   <= '0;
                    end
                end
                WrRow: begin
                    if (row_accept) begin
                        if (!last_row) begin
                            row <= row + RowIdxW'(1);
                        end else begin
                            row <= '0;
                            if (!(fifo_full || push_ok)) begin
                                state <= WrIdle;
                            end
                        end
                    end
                end
                default: begin
                    state <= WrIdle;
                    row   <= '0;
                end
            endcase
        end
    end

    // Job bookkeeping. A start is only taken while idle, so it never races a
    // completing block or a dropped one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blocks_written_o <= '0;
            overflow_o       <= 1'b0;
        end else if (start_ok) begin
            blocks_written_o <= '0;
            overflow_o       <= 1'b0;
        end else begin
            if (block_done) begin
                blocks_written_o <= blocks_written_o + AddrWidth'(1);
            end
            if (result_valid_i && !push_ok) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // The low AddrWidth bits of a sum of products depend only on the low
    // AddrWidth bits of the operands, so working at AddrWidth gives the same
    // result as the full-width product truncated afterwards.
    assign row_base   = head.m_idx * AddrWidth'(Mu) + AddrWidth'(row);
    assign job_blocks = M_size_i * N_size_i;

    assign sram_if.sram_wr_en   = wr_active;
    assign sram_if.sram_wr_addr = wr_active ? (row_base * N_size_i + head.n_idx) : '0;
    assign sram_if.sram_wr_data = wr_active ? head.data[row*RowWidth +: RowWidth] : '0;

    assign all_written_o = (blocks_written_o == job_blocks) && fifo_empty && !wr_active
                           && (M_size_i != '0);

endmodule
